// File: rtl/fetch_scheduler_if.sv
// Control/status bundle between the host control registers, the fetch
// scheduler and the PC selector of the four-thread barrel fetch stage.
interface fetch_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic [3:0]       thread_en;
    logic             stall;
    logic             ex_halt;
    logic [1:0]       ex_thread_id;
    logic             advance;
    logic             pc_reset_pulse;
    logic             fetch_valid;
    logic [1:0]       cur_thread;
    logic [3:0]       thread_active;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] run_cycles;
    logic [CNT_W-1:0] issue_count;

    modport master (
        output start, stop, thread_en, stall, ex_halt, ex_thread_id,
        input  advance, pc_reset_pulse, fetch_valid, cur_thread,
               thread_active, busy, done, run_cycles, issue_count
    );

    modport slave (
        input  start, stop, thread_en, stall, ex_halt, ex_thread_id,
        output advance, pc_reset_pulse, fetch_valid, cur_thread,
               thread_active, busy, done, run_cycles, issue_count
    );
endinterface

// File: rtl/fetch_scheduler.sv
// Barrel fetch sequencer: advance strobe, PC reset pulse, live-thread tracking,
// pipeline drain on stop/all-halted, and saturating run/issue counters.
module fetch_scheduler #(
    parameter int DRAIN_CYCLES = 5,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    fetch_scheduler_if.slave  bus
);
    localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESET_PC = 3'd1,
        ST_RUN      = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [3:0]       thread_active_r;
    logic [3:0]       active_next_s;
    logic [3:0]       halt_mask_s;
    logic [1:0]       cur_thread_r;
    logic             pc_reset_pulse_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] run_cycles_r;
    logic [CNT_W-1:0] issue_count_r;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic             advance_s;
    logic             fetch_valid_s;
    logic             load_drain_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Live mask after this cycle's halt; a halt takes effect at the next edge.
    always_comb begin
        halt_mask_s = 4'b0000;
        if (bus.ex_halt) begin
            halt_mask_s = 4'b0001 << bus.ex_thread_id;
        end else begin
            halt_mask_s = 4'b0000;
        end
        active_next_s = thread_active_r & ~halt_mask_s;
    end

    // Next-state decode plus the combinational advance/fetch_valid strobes.
    always_comb begin
        state_s       = state_r;
        advance_s     = 1'b0;
        fetch_valid_s = 1'b0;
        load_drain_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_s = ST_RESET_PC;
                else           state_s = ST_IDLE;
            end
            ST_RESET_PC: begin
                if (bus.thread_en == 4'b0000) begin
                    state_s      = ST_DRAIN;
                    load_drain_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RUN: begin
                advance_s     = ~bus.stall;
                fetch_valid_s = ~bus.stall & thread_active_r[cur_thread_r];
                // stop and the last halt together still make one transition
                if (bus.stop || (active_next_s == 4'b0000)) begin
                    state_s      = ST_DRAIN;
                    load_drain_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                advance_s = ~bus.stall;
                if (drain_cnt_r == DRAIN_W'(0)) state_s = ST_DONE;
                else                            state_s = ST_DRAIN;
            end
            ST_DONE: begin
                if (bus.start) state_s = ST_RESET_PC;
                else           state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register with registered state decodes for pulse, busy and done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            pc_reset_pulse_r <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
        end else begin
            state_r          <= state_s;
            pc_reset_pulse_r <= (state_s == ST_RESET_PC);
            busy_r           <= (state_s == ST_RESET_PC) || (state_s == ST_RUN) ||
                                (state_s == ST_DRAIN);
            if (state_s == ST_DONE)          done_r <= 1'b1;
            else if (state_r == ST_RESET_PC) done_r <= 1'b0;
        end
    end

    // Thread pointer, live mask, drain counter and saturating counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thread_active_r <= 4'b0000;
            cur_thread_r    <= 2'd0;
            run_cycles_r    <= '0;
            issue_count_r   <= '0;
            drain_cnt_r     <= '0;
        end else begin
            if (state_r == ST_RESET_PC) begin
                thread_active_r <= bus.thread_en;
                cur_thread_r    <= 2'd0;
                run_cycles_r    <= '0;
                issue_count_r   <= '0;
            end else begin
                if ((state_r == ST_RUN) || (state_r == ST_DRAIN)) begin
                    thread_active_r <= active_next_s;
                    run_cycles_r    <= sat_inc(run_cycles_r);
                end
                // the PC selector rotates unconditionally, so no mask skipping here
                if (advance_s)     cur_thread_r  <= cur_thread_r + 2'd1;
                if (fetch_valid_s) issue_count_r <= sat_inc(issue_count_r);
            end
            if (load_drain_s) begin
                drain_cnt_r <= DRAIN_LOAD;
            end else if ((state_r == ST_DRAIN) && advance_s && (drain_cnt_r != DRAIN_W'(0))) begin
                drain_cnt_r <= drain_cnt_r - DRAIN_W'(1);
            end
        end
    end

    assign bus.advance        = advance_s;
    assign bus.fetch_valid    = fetch_valid_s;
    assign bus.pc_reset_pulse = pc_reset_pulse_r;
    assign bus.cur_thread     = cur_thread_r;
    assign bus.thread_active  = thread_active_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.run_cycles     = run_cycles_r;
    assign bus.issue_count    = issue_count_r;
endmodule

// File: tb/tb_fetch_scheduler.sv
// Directed bench for fetch_scheduler: inputs change on the falling edge and
// outputs are compared 1 time unit later against hand-computed values.
module tb_fetch_scheduler;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_scheduler_if #(.CNT_W(16)) bus ();

    fetch_scheduler #(.DRAIN_CYCLES(5), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 30; k++) begin
            if (bus.done) break;
            tick();
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL rst_advance got %b exp 0", bus.advance); end
        checks++; if (bus.pc_reset_pulse !== 1'b0) begin errors++; $display("FAIL rst_pulse got %b exp 0", bus.pc_reset_pulse); end
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_fv got %b exp 0", bus.fetch_valid); end
        checks++; if (bus.cur_thread !== 2'd0) begin errors++; $display("FAIL rst_cur got %0d exp 0", bus.cur_thread); end
        checks++; if (bus.thread_active !== 4'b0000) begin errors++; $display("FAIL rst_ta got %b exp 0000", bus.thread_active); end
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done got %b exp 00", {bus.busy, bus.done}); end
        checks++; if ({bus.run_cycles, bus.issue_count} !== 32'd0) begin errors++; $display("FAIL rst_counters got %h exp 0", {bus.run_cycles, bus.issue_count}); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        #1;
        checks++; if ({bus.busy, bus.advance} !== 2'b00) begin errors++; $display("FAIL idle_busy_adv got %b exp 00", {bus.busy, bus.advance}); end
    endtask

    task automatic test_basic();
        bus.thread_en = 4'b1111; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; #1;
        checks++; if ({bus.pc_reset_pulse, bus.advance, bus.busy} !== 3'b101) begin errors++; $display("FAIL basic_resetpc got %b exp 101", {bus.pc_reset_pulse, bus.advance, bus.busy}); end
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.cur_thread !== i[1:0]) begin errors++; $display("FAIL basic_cur[%0d] got %0d exp %0d", i, bus.cur_thread, i[1:0]); end
            checks++; if ({bus.advance, bus.fetch_valid, bus.pc_reset_pulse} !== 3'b110) begin errors++; $display("FAIL basic_strobes[%0d] got %b exp 110", i, {bus.advance, bus.fetch_valid, bus.pc_reset_pulse}); end
            checks++; if (bus.issue_count !== 16'(i)) begin errors++; $display("FAIL basic_issue[%0d] got %0d exp %0d", i, bus.issue_count, i); end
            tick();
        end
        #1;
        checks++; if (bus.run_cycles !== 16'd5) begin errors++; $display("FAIL basic_run got %0d exp 5", bus.run_cycles); end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        wait_done();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done_timeout got %b exp 1", bus.done); end
    endtask

    task automatic test_restart_sparse();
        bus.thread_en = 4'b0101; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; #1;
        checks++; if ({bus.done, bus.pc_reset_pulse} !== 2'b11) begin errors++; $display("FAIL restart_resetpc got %b exp 11", {bus.done, bus.pc_reset_pulse}); end
        tick();
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL restart_done_drop got %b exp 0", bus.done); end
        checks++; if ({bus.run_cycles, bus.issue_count} !== 32'd0) begin errors++; $display("FAIL restart_counters got %h exp 0", {bus.run_cycles, bus.issue_count}); end
        checks++; if (bus.thread_active !== 4'b0101) begin errors++; $display("FAIL sparse_ta got %b exp 0101", bus.thread_active); end
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if ({bus.cur_thread, bus.fetch_valid} !== {i[1:0], ~i[0]}) begin errors++; $display("FAIL sparse_fv[%0d] got %b exp %b", i, {bus.cur_thread, bus.fetch_valid}, {i[1:0], ~i[0]}); end
            tick();
        end
        #1;
        checks++; if (bus.issue_count !== 16'd4) begin errors++; $display("FAIL sparse_issue got %0d exp 4", bus.issue_count); end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        wait_done();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL sparse_done_timeout got %b exp 1", bus.done); end
    endtask

    task automatic test_halt_all();
        bus.thread_en = 4'b0011; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.ex_halt = 1'b1; bus.ex_thread_id = 2'd0; #1;
        checks++; if ({bus.thread_active, bus.fetch_valid} !== 5'b0011_1) begin errors++; $display("FAIL halt_c0 got %b exp 00111", {bus.thread_active, bus.fetch_valid}); end
        tick();
        bus.ex_thread_id = 2'd3; #1;
        checks++; if ({bus.thread_active, bus.cur_thread, bus.fetch_valid} !== 7'b0010_01_1) begin errors++; $display("FAIL halt_c1 got %b exp 0010011", {bus.thread_active, bus.cur_thread, bus.fetch_valid}); end
        tick();
        bus.ex_thread_id = 2'd1; #1;
        checks++; if ({bus.thread_active, bus.fetch_valid, bus.busy} !== 6'b0010_0_1) begin errors++; $display("FAIL halt_c2 got %b exp 001001", {bus.thread_active, bus.fetch_valid, bus.busy}); end
        tick();
        bus.ex_halt = 1'b0;
        for (int d = 0; d < 6; d++) begin
            #1;
            checks++; if ({bus.done, bus.fetch_valid, bus.advance, bus.thread_active} !== 7'b001_0000) begin errors++; $display("FAIL halt_drain[%0d] got %b exp 0010000", d, {bus.done, bus.fetch_valid, bus.advance, bus.thread_active}); end
            tick();
        end
        #1;
        checks++; if ({bus.done, bus.advance, bus.busy, bus.thread_active} !== 7'b100_0000) begin errors++; $display("FAIL halt_done got %b exp 1000000", {bus.done, bus.advance, bus.busy, bus.thread_active}); end
        checks++; if ({bus.issue_count, bus.run_cycles} !== {16'd2, 16'd9}) begin errors++; $display("FAIL halt_counts got issue %0d run %0d exp 2 9", bus.issue_count, bus.run_cycles); end
        checks++; if (bus.cur_thread !== 2'd1) begin errors++; $display("FAIL halt_cur got %0d exp 1", bus.cur_thread); end
    endtask

    task automatic test_stop_stall();
        bus.thread_en = 4'b1111; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        for (int d = 0; d < 9; d++) begin
            bus.stall = (d >= 2) && (d <= 4); #1;
            checks++; if ({bus.done, bus.advance} !== {1'b0, ~bus.stall}) begin errors++; $display("FAIL stall_drain[%0d] got %b exp %b", d, {bus.done, bus.advance}, {1'b0, ~bus.stall}); end
            tick();
        end
        bus.stall = 1'b0; #1;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL stall_done got %b exp 1", bus.done); end
        checks++; if ({bus.run_cycles, bus.issue_count} !== {16'd10, 16'd1}) begin errors++; $display("FAIL stall_counts got run %0d issue %0d exp 10 1", bus.run_cycles, bus.issue_count); end
        checks++; if (bus.cur_thread !== 2'd3) begin errors++; $display("FAIL stall_cur got %0d exp 3", bus.cur_thread); end
    endtask

    task automatic test_reset_mid();
        bus.thread_en = 4'b1111; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        #1;
        checks++; if (bus.cur_thread !== 2'd2) begin errors++; $display("FAIL mid_cur_before got %0d exp 2", bus.cur_thread); end
        reset = 1'b1; #1;
        checks++; if ({bus.advance, bus.pc_reset_pulse, bus.fetch_valid, bus.busy, bus.done} !== 5'b00000) begin errors++; $display("FAIL mid_flags got %b exp 00000", {bus.advance, bus.pc_reset_pulse, bus.fetch_valid, bus.busy, bus.done}); end
        checks++; if ({bus.cur_thread, bus.thread_active, bus.run_cycles, bus.issue_count} !== 38'd0) begin errors++; $display("FAIL mid_state got %h exp 0", {bus.cur_thread, bus.thread_active, bus.run_cycles, bus.issue_count}); end
        tick();
        reset = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0; #1;
        checks++; if (bus.pc_reset_pulse !== 1'b1) begin errors++; $display("FAIL mid_restart_pulse got %b exp 1", bus.pc_reset_pulse); end
        tick();
        #1;
        checks++; if ({bus.cur_thread, bus.fetch_valid, bus.advance, bus.issue_count} !== {2'd0, 2'b11, 16'd0}) begin errors++; $display("FAIL mid_restart_run got %h exp %h", {bus.cur_thread, bus.fetch_valid, bus.advance, bus.issue_count}, {2'd0, 2'b11, 16'd0}); end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        wait_done();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL mid_done_timeout got %b exp 1", bus.done); end
    endtask

    task automatic test_zero_mask();
        bus.thread_en = 4'b0000; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; #1;
        checks++; if (bus.pc_reset_pulse !== 1'b1) begin errors++; $display("FAIL zero_pulse got %b exp 1", bus.pc_reset_pulse); end
        tick();
        #1;
        checks++; if ({bus.thread_active, bus.busy, bus.fetch_valid, bus.advance} !== 7'b0000_101) begin errors++; $display("FAIL zero_drain_entry got %b exp 0000101", {bus.thread_active, bus.busy, bus.fetch_valid, bus.advance}); end
        for (int d = 0; d < 6; d++) begin
            #1;
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_drain[%0d] got %b exp 0", d, bus.done); end
            tick();
        end
        #1;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", bus.done); end
        checks++; if ({bus.issue_count, bus.run_cycles} !== {16'd0, 16'd6}) begin errors++; $display("FAIL zero_counts got issue %0d run %0d exp 0 6", bus.issue_count, bus.run_cycles); end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.thread_en    = 4'b0000;
        bus.stall        = 1'b0;
        bus.ex_halt      = 1'b0;
        bus.ex_thread_id = 2'd0;
        test_reset();
        test_basic();
        test_restart_sparse();
        test_halt_all();
        test_stop_stall();
        test_reset_mid();
        test_zero_mask();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
